// File: rtl/mon_link_pkg.sv
// Shared types and constants for the monitor-link transmitter.
package mon_link_pkg;

  localparam int PKT_W = 40;

  typedef logic [PKT_W-1:0] pkt_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } tx_state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/mon_link_tx_fifo.sv
// Packet queue for the monitor-link transmitter.
// ready is a registered copy of "not full" computed from the next level,
// so it never depends on a pop in the same cycle.
// flush empties the queue at the next edge and drops a coincident push.
module mon_link_tx_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   ready,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      level_q;
  logic [AW:0]      level_d;
  logic             ready_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && ready_q && !flush;
  assign pop_ok  = pop && (level_q != '0);

  assign rdata = mem[rptr_q];
  assign empty = (level_q == '0);
  assign ready = ready_q;
  assign level = level_q;

  // Next occupancy: flush wins, otherwise push and pop cancel out.
  always_comb begin
    level_d = level_q;
    if (flush) begin
      level_d = '0;
    end else if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // Pointers, level and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ready_q <= 1'b0;
    end else begin
      level_q <= level_d;
      ready_q <= (level_d != FULL_LVL);
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push_ok) wptr_q <= wptr_q + 1'b1;
        if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // Packet storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/mon_link_tx.sv
// Monitor-link serial transmitter: queues 40-bit packets and sends each as
// start(0), data MSB first, [parity], stop(1), then IDLE_GAP idle bits.
// Optional build macro MON_LINK_TX_PARITY_EN inserts an even-parity bit
// between the data and the stop bit.
// to_mon, busy and pkt_sent are registered from the FSM state, so the line
// trails the state by one cycle and is glitch-free.
module mon_link_tx #(
  parameter int PKT_W    = 40,
  parameter int DEPTH    = 4,
  parameter int BIT_DIV  = 1,
  parameter int IDLE_GAP = 2
) (
  input  logic                   mon_clk,
  input  logic                   hw_reset_n,
  input  logic [PKT_W-1:0]       pkt_data,
  input  logic                   pkt_valid,
  output logic                   pkt_ready,
  input  logic                   flush,
  output logic                   to_mon,
  output logic                   busy,
  output logic                   pkt_sent,
  output logic [$clog2(DEPTH):0] fifo_level
);

  import mon_link_pkg::*;

  localparam int DW = $clog2(BIT_DIV) + 1;
  localparam int IW = $clog2(PKT_W + 1);
  localparam int GW = $clog2(IDLE_GAP + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(PKT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP - 1);

  tx_state_t        state_q;
  tx_state_t        state_d;
  logic [DW-1:0]    div_q;
  logic [DW-1:0]    div_d;
  logic [IW-1:0]    idx_q;
  logic [IW-1:0]    idx_d;
  logic [GW-1:0]    gap_q;
  logic [GW-1:0]    gap_d;
  logic [PKT_W-1:0] shreg_q;
  logic [PKT_W-1:0] fifo_rdata;
  logic             fifo_empty;
  logic             pop;
  logic             load;
  logic             shift;
  logic             line;
  logic             sent;
  logic             bit_end;
  logic             to_mon_q;
  logic             busy_q;
  logic             sent_q;
`ifdef MON_LINK_TX_PARITY_EN
  logic             parity_q;
`endif

  mon_link_tx_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (mon_clk),
    .rst_n (hw_reset_n),
    .flush (flush),
    .push  (pkt_valid),
    .wdata (pkt_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .empty (fifo_empty),
    .ready (pkt_ready),
    .level (fifo_level)
  );

  assign bit_end  = (div_q == DIV_LAST);
  assign to_mon   = to_mon_q;
  assign busy     = busy_q;
  assign pkt_sent = sent_q;

  // Next-state, line level and datapath strobes for the frame sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    sent    = 1'b0;
    line    = STOP_BIT;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        line = START_BIT;
        if (bit_end) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        line = shreg_q[PKT_W-1];
        if (bit_end) begin
          if (idx_q == BIT_LAST) begin
`ifdef MON_LINK_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            shift = 1'b1;
          end
        end
      end
`ifdef MON_LINK_TX_PARITY_EN
      PARITY: begin
        line = parity_q;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        line = STOP_BIT;
        if (bit_end) begin
          sent    = 1'b1;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        line = STOP_BIT;
        if (bit_end) begin
          if (gap_q == GAP_LAST) begin
            // Chain straight into the next frame when one is queued.
            if (!fifo_empty) begin
              pop     = 1'b1;
              load    = 1'b1;
              state_d = START;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit-period divider: idle at zero, otherwise counts 0..BIT_DIV-1.
  always_comb begin
    div_d = div_q;
    if (state_q == IDLE || bit_end) begin
      div_d = '0;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
    end
  end

  // Shift register: load on pop, shift left at each data bit boundary.
  always_ff @(posedge mon_clk) begin
    if (load) begin
      shreg_q <= fifo_rdata;
    end else if (shift) begin
      shreg_q <= {shreg_q[PKT_W-2:0], 1'b0};
    end
  end

`ifdef MON_LINK_TX_PARITY_EN
  // Even parity of the payload, captured when the packet is popped.
  always_ff @(posedge mon_clk) begin
    if (load) parity_q <= ^fifo_rdata;
  end
`endif

  // Registered outputs; reset drives the line high immediately.
  always_ff @(posedge mon_clk or negedge hw_reset_n) begin
    if (!hw_reset_n) begin
      to_mon_q <= STOP_BIT;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      to_mon_q <= line;
      busy_q   <= (state_q != IDLE);
      sent_q   <= sent;
    end
  end

endmodule

// File: tb/tb_mon_link_tx.sv
// Directed testbench for mon_link_tx: one instance with BIT_DIV=1 and one
// with BIT_DIV=4. Honours MON_LINK_TX_PARITY_EN for the expected frame length.
module tb_mon_link_tx;

`ifdef MON_LINK_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int GAPB = 2;
  localparam int F    = 1 + 40 + PAR + 1 + GAPB;  // line bits per frame

  logic        clk;
  logic        rst_n;
  logic [39:0] data1;
  logic        valid1;
  logic        ready1;
  logic        flush1;
  logic        line1;
  logic        busy1;
  logic        sent1;
  logic [2:0]  level1;
  logic [39:0] data4;
  logic        valid4;
  logic        ready4;
  logic        flush4;
  logic        line4;
  logic        busy4;
  logic        sent4;
  logic [2:0]  level4;

  int checks;
  int errors;

  mon_link_tx #(.PKT_W(40), .DEPTH(4), .BIT_DIV(1), .IDLE_GAP(GAPB)) dut1 (
    .mon_clk(clk), .hw_reset_n(rst_n), .pkt_data(data1), .pkt_valid(valid1),
    .pkt_ready(ready1), .flush(flush1), .to_mon(line1), .busy(busy1),
    .pkt_sent(sent1), .fifo_level(level1)
  );

  mon_link_tx #(.PKT_W(40), .DEPTH(4), .BIT_DIV(4), .IDLE_GAP(GAPB)) dut4 (
    .mon_clk(clk), .hw_reset_n(rst_n), .pkt_data(data4), .pkt_valid(valid4),
    .pkt_ready(ready4), .flush(flush4), .to_mon(line4), .busy(busy4),
    .pkt_sent(sent4), .fifo_level(level4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected line level at bit-time k of a frame carrying d.
  function automatic logic exp_line(input logic [39:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 40) return d[40-k];
    if (PAR == 1 && k == 41) return ^d;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data1 = '0; valid1 = 1'b0; flush1 = 1'b0;
    data4 = '0; valid4 = 1'b0; flush4 = 1'b0;
    tick(); tick();
    checks++; if (line1 !== 1'b1) begin errors++; $display("FAIL rst_to_mon: got %b expected 1", line1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy1); end
    checks++; if (sent1 !== 1'b0) begin errors++; $display("FAIL rst_sent: got %b expected 0", sent1); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL rst_ready_held: got %b expected 0", ready1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", level1); end
    checks++; if (line4 !== 1'b1) begin errors++; $display("FAIL rst_to_mon4: got %b expected 1", line4); end
    rst_n = 1'b1;
    tick();
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL rst_ready_release: got %b expected 1", ready1); end
    checks++; if (ready4 !== 1'b1) begin errors++; $display("FAIL rst_ready4_release: got %b expected 1", ready4); end
  endtask

  task automatic test_single_frame();
    logic [39:0] d;
    int nsent;
    d = 40'hA5_0000_1234;
    nsent = 0;
    data1 = d; valid1 = 1'b1;
    tick();                       // push at edge N
    valid1 = 1'b0;
    checks++; if (level1 !== 3'd1) begin errors++; $display("FAIL single_level_after_push: got %0d expected 1", level1); end
    tick();                       // edge N+1: still high
    checks++; if (line1 !== 1'b1) begin errors++; $display("FAIL single_latency_n1: got %b expected 1", line1); end
    for (int k = 0; k <= F; k++) begin
      tick();                     // edge N+2+k
      if (k < F) begin
        checks++; if (line1 !== exp_line(d, k)) begin errors++; $display("FAIL single_bit%0d: got %b expected %b", k, line1, exp_line(d, k)); end
      end
      checks++; if (busy1 !== (k < F)) begin errors++; $display("FAIL single_busy%0d: got %b expected %b", k, busy1, (k < F)); end
      if (sent1) begin
        nsent++;
        checks++; if (k != 41 + PAR) begin errors++; $display("FAIL single_sent_pos: got %0d expected %0d", k, 41 + PAR); end
      end
    end
    checks++; if (nsent != 1) begin errors++; $display("FAIL single_sent_count: got %0d expected 1", nsent); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] p [5];
    int tot;
    int k;
    int j;
    int m;
    p[0] = 40'h11_2233_4455; p[1] = 40'hF0_0F0F_F00F; p[2] = 40'h80_0000_0001;
    p[3] = 40'h7F_FFFF_FFFE; p[4] = 40'h3C_A596_5AC3;
    tot = 2 + 5 * F + 3;
    data1 = p[0]; valid1 = 1'b1;
    checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_initial: got %b expected 1", ready1); end
    for (int t = 0; t < tot; t++) begin
      tick();                     // edge N+t
      if (t < 4) data1 = p[t+1];
      else if (t == 4) data1 = 40'hDEAD_BEEF_00;
      else valid1 = 1'b0;
      if (t < 4) begin
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL b2b_ready_t%0d: got %b expected 1", t, ready1); end
      end
      if (t == 4 || t == 5) begin
        checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL b2b_full_ready_t%0d: got %b expected 0", t, ready1); end
        checks++; if (level1 !== 3'd4) begin errors++; $display("FAIL b2b_full_level_t%0d: got %0d expected 4", t, level1); end
      end
      if (t >= 2 && t < 2 + 5 * F) begin
        k = t - 2; j = k / F; m = k % F;
        checks++; if (line1 !== exp_line(p[j], m)) begin errors++; $display("FAIL b2b_f%0d_bit%0d: got %b expected %b", j, m, line1, exp_line(p[j], m)); end
        if (m == 0 && j >= 1) begin
          checks++; if (level1 !== 3'(4 - j)) begin errors++; $display("FAIL b2b_level_f%0d: got %0d expected %0d", j, level1, 4 - j); end
        end
      end else if (t >= 2 + 5 * F) begin
        checks++; if (line1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL b2b_tail: got line %b busy %b expected 1 0", line1, busy1); end
      end
    end
  endtask

  task automatic test_bit_div4();
    logic [39:0] d;
    int nbusy;
    int nsent;
    int k;
    d = 40'hFF_FFFF_FFFF;
    nbusy = 0; nsent = 0;
    data4 = d; valid4 = 1'b1;
    tick();                       // push at edge N
    valid4 = 1'b0;
    for (int t = 1; t < 2 + 4 * F + 4; t++) begin
      tick();
      if (busy4) nbusy++;
      if (sent4) nsent++;
      if (t == 1) begin
        checks++; if (line4 !== 1'b1) begin errors++; $display("FAIL div4_latency: got %b expected 1", line4); end
      end else if (t < 2 + 4 * F) begin
        k = (t - 2) / 4;
        checks++; if (line4 !== exp_line(d, k)) begin errors++; $display("FAIL div4_cyc%0d: got %b expected %b", t - 2, line4, exp_line(d, k)); end
      end
    end
    checks++; if (nbusy != 4 * F) begin errors++; $display("FAIL div4_busy_cycles: got %0d expected %0d", nbusy, 4 * F); end
    checks++; if (nsent != 1) begin errors++; $display("FAIL div4_sent_count: got %0d expected 1", nsent); end
  endtask

  task automatic test_flush();
    logic [39:0] q [3];
    int nsent;
    int k;
    q[0] = 40'hC0_FFEE_0102; q[1] = 40'h00_0000_0000; q[2] = 40'h12_3456_789A;
    nsent = 0;
    data1 = q[0]; valid1 = 1'b1;
    for (int t = 0; t < 2 + 3 * F; t++) begin
      tick();                     // edge N+t
      if (t == 0) data1 = q[1];
      if (t == 1) data1 = q[2];
      if (t == 2) valid1 = 1'b0;
      if (t == 3) begin
        checks++; if (level1 !== 3'd2) begin errors++; $display("FAIL flush_level_before: got %0d expected 2", level1); end
      end
      if (t == 12) begin          // mid-DATA, with a push that must be dropped
        flush1 = 1'b1; valid1 = 1'b1; data1 = 40'hAB_CDEF_0123;
      end
      if (t == 13) begin
        flush1 = 1'b0; valid1 = 1'b0;
        checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL flush_level_after: got %0d expected 0", level1); end
      end
      if (sent1) nsent++;
      if (t >= 2) begin
        k = t - 2;
        if (k < F) begin
          checks++; if (line1 !== exp_line(q[0], k)) begin errors++; $display("FAIL flush_f0_bit%0d: got %b expected %b", k, line1, exp_line(q[0], k)); end
        end else begin
          checks++; if (line1 !== 1'b1 || busy1 !== 1'b0) begin errors++; $display("FAIL flush_no_resend_k%0d: got line %b busy %b expected 1 0", k, line1, busy1); end
        end
      end
    end
    checks++; if (nsent != 1) begin errors++; $display("FAIL flush_sent_count: got %0d expected 1", nsent); end
  endtask

  task automatic test_async_reset();
    logic [39:0] d;
    d = 40'hC3_5A00_0F0F;
    data1 = 40'h00_0000_0000; valid1 = 1'b1;
    tick();                       // edge N
    data1 = 40'h00_0000_0001;
    tick();                       // edge N+1
    valid1 = 1'b0;
    for (int t = 2; t <= 10; t++) tick();
    checks++; if (line1 !== 1'b0) begin errors++; $display("FAIL arst_mid_data_line: got %b expected 0", line1); end
    checks++; if (level1 !== 3'd1) begin errors++; $display("FAIL arst_level_before: got %0d expected 1", level1); end
    #2;
    rst_n = 1'b0;
    #1;                           // same cycle, no clock edge yet
    checks++; if (line1 !== 1'b1) begin errors++; $display("FAIL arst_line_async: got %b expected 1", line1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL arst_busy_async: got %b expected 0", busy1); end
    checks++; if (level1 !== 3'd0) begin errors++; $display("FAIL arst_level_async: got %0d expected 0", level1); end
    checks++; if (ready1 !== 1'b0) begin errors++; $display("FAIL arst_ready_async: got %b expected 0", ready1); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (busy1 !== 1'b0 || level1 !== 3'd0 || ready1 !== 1'b1) begin errors++; $display("FAIL arst_release: got busy %b level %0d ready %b expected 0 0 1", busy1, level1, ready1); end
    for (int t = 0; t < 50; t++) begin
      tick();
      checks++; if (line1 !== 1'b1) begin errors++; $display("FAIL arst_no_resend_t%0d: got %b expected 1", t, line1); end
    end
    data1 = d; valid1 = 1'b1;
    tick();                       // push at edge N
    valid1 = 1'b0;
    tick();
    for (int k = 0; k < F; k++) begin
      tick();
      checks++; if (line1 !== exp_line(d, k)) begin errors++; $display("FAIL arst_after_bit%0d: got %b expected %b", k, line1, exp_line(d, k)); end
    end
    tick();
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL arst_after_busy_end: got %b expected 0", busy1); end
  endtask

`ifdef MON_LINK_TX_PARITY_EN
  task automatic test_parity();
    logic [39:0] v [2];
    logic        pbit [2];
    v[0] = 40'h00_0000_0001; pbit[0] = 1'b1;
    v[1] = 40'h00_0000_0003; pbit[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data1 = v[i]; valid1 = 1'b1;
      tick();
      valid1 = 1'b0;
      tick();
      for (int k = 0; k <= F; k++) begin
        tick();
        if (k == 41) begin
          checks++; if (line1 !== pbit[i]) begin errors++; $display("FAIL parity_v%0d: got %b expected %b", i, line1, pbit[i]); end
        end else if (k < F) begin
          checks++; if (line1 !== exp_line(v[i], k)) begin errors++; $display("FAIL parity_v%0d_bit%0d: got %b expected %b", i, k, line1, exp_line(v[i], k)); end
        end
      end
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_bit_div4();
    test_flush();
    test_async_reset();
`ifdef MON_LINK_TX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
